slow2fast_gray_count_sync: RTL and testbench

- Carries a free-running event counter from the slow clk2 domain into the fast clk1 domain. This is the opposite direction of our fast-to-slow counter path.
- Only a registered Gray-coded value crosses domains. The clk1 side passes it through a multi-flop synchronizer and decodes it back to binary.
- The clk1 side flags each update and detects any multi-bit step, which would indicate a CDC violation.
- The block sits between slow-domain event logic and fast-domain consumers such as monitors and rate counters.

---
 rtl/slow2fast_gray_count_sync.sv | 108 ++++++++++
 tb/tb_slow2fast_gray_count_sync.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/slow2fast_gray_count_sync.sv
`timescale 1ns/1ps
// slow2fast_gray_count_sync
// Carries a free-running event counter from the slow clk2 domain into the
// fast clk1 domain. The only crossing signal is the registered Gray code
// gray_2. On the clk1 side it is synchronized, decoded back to binary and
// checked for multi-bit steps. A multi-bit step means clk1 missed
// increments, which is a CDC violation.
module slow2fast_gray_count_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DIV         = 3
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             clk2,
    input  logic             en_2,
    output logic [WIDTH-1:0] count_2,
    output logic [WIDTH-1:0] gray_2,
    output logic [WIDTH-1:0] count_1,
    output logic             count_valid_1,
    output logic             step_err_1,
    input  logic             clear_err_1
);

    // A one-bit prescaler is kept for DIV=1; it then never leaves 0.
    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]                  pre;
    logic [WIDTH-1:0]                  count_next;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  gs;
    logic [WIDTH-1:0]                  prev_g;
    logic [WIDTH-1:0]                  gs_bin;
    logic [WIDTH-1:0]                  step_diff;
    logic                              step_new;
    logic                              step_multi;

    assign count_next = count_2 + WIDTH'(1);

    // clk2: the prescaler gates the counter. gray_2 is loaded from the same
    // next value as count_2, so gray_2 always equals gray(count_2).
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            pre     <= '0;
            count_2 <= '0;
            gray_2  <= '0;
        end else if (en_2) begin
            if (pre == PRE_LAST) begin
                pre     <= '0;
                count_2 <= count_next;
                gray_2  <= count_next ^ (count_next >> 1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    // clk1: synchronizer chain fed straight from the gray_2 flop.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gray_2};
        end else begin
            sync_q[0] <= gray_2;
        end
    end

    assign gs = sync_q[SYNC_STAGES-1];

    // Gray-to-binary: binary bit i is the XOR of Gray bits WIDTH-1 down to i.
    always_comb begin
        gs_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gs_bin[i] = ^(gs >> i);
        end
    end

    // More than one set bit in the difference means a multi-bit step.
    // Clearing the lowest set bit leaves a nonzero value exactly in that case.
    assign step_diff  = gs ^ prev_g;
    assign step_new   = |step_diff;
    assign step_multi = |(step_diff & (step_diff - WIDTH'(1)));

    // clk1: accept a changed Gray value, pulse valid, and keep a sticky error.
    // A new error on the same edge as a clear wins over the clear.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            prev_g        <= '0;
            count_1       <= '0;
            count_valid_1 <= 1'b0;
            step_err_1    <= 1'b0;
        end else begin
            count_valid_1 <= step_new;
            if (step_new) begin
                prev_g  <= gs;
                count_1 <= gs_bin;
            end
            if (step_new && step_multi) begin
                step_err_1 <= 1'b1;
            end else if (clear_err_1) begin
                step_err_1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_slow2fast_gray_count_sync.sv
`timescale 1ns/1ps
// Directed bench for slow2fast_gray_count_sync (WIDTH=4, SYNC_STAGES=2, DIV=3).
module tb_slow2fast_gray_count_sync;

    logic       clk1 = 1'b0;
    logic       clk2 = 1'b0;
    logic       reset = 1'b0;
    logic       en_2 = 1'b0;
    logic       clear_err_1 = 1'b0;
    logic [3:0] count_2;
    logic [3:0] gray_2;
    logic [3:0] count_1;
    logic       count_valid_1;
    logic       step_err_1;

    realtime half1 = 5.0;
    realtime half2 = 15.0;
    bit      run1  = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    slow2fast_gray_count_sync #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DIV(3)
    ) dut (
        .clk1(clk1),
        .reset(reset),
        .clk2(clk2),
        .en_2(en_2),
        .count_2(count_2),
        .gray_2(gray_2),
        .count_1(count_1),
        .count_valid_1(count_valid_1),
        .step_err_1(step_err_1),
        .clear_err_1(clear_err_1)
    );

    // clk1 can be parked low so the bench can control exactly when it samples.
    always begin
        #(half1);
        if (run1) clk1 = ~clk1;
    end

    // Free-running clk2.
    always begin
        #(half2);
        clk2 = ~clk2;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for count_2 to reach exp_val, then check the clk1-side update:
    // latency, single valid pulse, decoded value and no error.
    task automatic wait_step(input logic [3:0] exp_val, input string tag, output int n_wait);
        int  k;
        int  early;
        bit  seen;
        early  = 0;
        seen   = 1'b0;
        n_wait = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk1);
            n_wait++;
            if (count_2 == exp_val) seen = 1'b1;
            else if (count_valid_1) early++;
        end
        check($sformatf("%s count_2", tag), count_2, exp_val);
        check($sformatf("%s gray_2", tag), gray_2, exp_val ^ (exp_val >> 1));
        check($sformatf("%s no stray valid", tag), early, 0);
        k    = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk1);
            k++;
            if (count_valid_1) seen = 1'b1;
        end
        check($sformatf("%s latency 3..4 (k=%0d)", tag, k), (k >= 3 && k <= 4), 1);
        check($sformatf("%s count_1", tag), count_1, exp_val);
        check($sformatf("%s step_err_1", tag), step_err_1, 0);
        @(negedge clk1);
        check($sformatf("%s single pulse", tag), count_valid_1, 0);
    endtask

    initial begin
        int n_wait;
        int vcount;
        logic [3:0] v;
        bit  got;

        // Reset: every output at 0
        #1 reset = 1'b1;
        #2;
        check("rst count_2", count_2, 0);
        check("rst gray_2", gray_2, 0);
        check("rst count_1", count_1, 0);
        check("rst count_valid_1", count_valid_1, 0);
        check("rst step_err_1", step_err_1, 0);
        @(negedge clk2);
        reset = 1'b0;
        en_2  = 1'b1;

        // Basic transfer: steps 1..5, one increment per 90 ns
        wait_step(4'd1, "step1", n_wait);
        for (int s = 2; s <= 5; s++) begin
            v = 4'(s);
            wait_step(v, $sformatf("step%0d", s), n_wait);
            check($sformatf("step%0d period", s), n_wait, 5);
        end

        // Enable hold at 5 for 20 clk2 cycles
        @(negedge clk2);
        en_2   = 1'b0;
        vcount = 0;
        repeat (60) begin
            @(negedge clk1);
            if (count_valid_1) vcount++;
        end
        check("hold valid pulses", vcount, 0);
        check("hold count_2", count_2, 5);
        check("hold count_1", count_1, 5);
        @(negedge clk2);
        en_2 = 1'b1;
        wait_step(4'd6, "resume", n_wait);
        check($sformatf("resume within DIV clk2 (n=%0d)", n_wait), (n_wait <= 10), 1);

        // Wrap: 7..15, 0, 1, then on to 9
        for (int s = 7; s <= 25; s++) begin
            v = 4'(s);
            wait_step(v, $sformatf("wrap%0d", s), n_wait);
            check($sformatf("wrap%0d period", s), n_wait, 5);
        end

        // Mid-run reset at count_1 = 9
        reset = 1'b1;
        #1;
        check("midrst count_2", count_2, 0);
        check("midrst gray_2", gray_2, 0);
        check("midrst count_1", count_1, 0);
        check("midrst count_valid_1", count_valid_1, 0);
        check("midrst step_err_1", step_err_1, 0);
        @(negedge clk2);
        reset = 1'b0;
        wait_step(4'd1, "post-reset", n_wait);

        // Violation: clk2 5 ns, clk1 40 ns, increments every 15 ns
        half1 = 20.0;
        half2 = 2.5;
        repeat (30) @(negedge clk1);
        check("violation step_err_1", step_err_1, 1);
        @(negedge clk2);
        en_2  = 1'b0;
        half1 = 5.0;
        half2 = 15.0;
        repeat (10) @(negedge clk1);
        check("violation sticky", step_err_1, 1);
        clear_err_1 = 1'b1;
        @(negedge clk1);
        clear_err_1 = 1'b0;
        check("clear step_err_1", step_err_1, 0);
        check("clear no valid", count_valid_1, 0);

        // Clear/error collision: two increments while clk1 is parked
        reset = 1'b1;
        repeat (2) @(negedge clk1);
        #0.1 reset = 1'b0;
        repeat (5) @(negedge clk1);
        check("coll pre step_err_1", step_err_1, 0);
        check("coll pre count_1", count_1, 0);
        @(negedge clk1);
        run1 = 1'b0;
        @(negedge clk2);
        en_2 = 1'b1;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk2);
            if (count_2 == 4'd2) got = 1'b1;
        end
        en_2 = 1'b0;
        check("coll count_2", count_2, 2);
        check("coll gray_2", gray_2, 3);
        run1 = 1'b1;
        @(posedge clk1);
        @(posedge clk1);
        @(negedge clk1);
        check("coll before err", step_err_1, 0);
        check("coll before valid", count_valid_1, 0);
        clear_err_1 = 1'b1;
        @(negedge clk1);
        check("coll err wins", step_err_1, 1);
        check("coll valid", count_valid_1, 1);
        check("coll count_1 jump", count_1, 2);
        @(negedge clk1);
        check("coll later clear", step_err_1, 0);
        check("coll valid end", count_valid_1, 0);
        clear_err_1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
